led_pattern_gen: RTL and testbench

//   Multi-channel LED driver: successor to the single-output divider blinker on the FPGA top sheet.

---
 rtl/led_pattern_gen_if.sv | 25 ++
 rtl/led_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Configuration port for led_pattern_gen.
// Handshake: a transfer happens on a rising clock edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_ch/mode/period/duty stable
// while cfg_valid is high. The slave may drop cfg_ready at any time.
interface led_pattern_gen_if #(
  parameter int CH_W     = 2,
  parameter int PWM_BITS = 8
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [15:0]         cfg_period;
  logic [PWM_BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver. A shared prescaler produces a one-cycle TICK at
// TICK_HZ; every channel runs OFF, ON, BLINK (tick-timed half-period) or PWM
// (shared free-running counter against a per-channel duty). Channel modes are
// loaded at run time through the config port. LED outputs are registered.
module led_pattern_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1_000,
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  led_pattern_gen_if.slave    i_cfg,
  output logic                o_tick,
  output logic [CHANNELS-1:0] o_led,
  output logic [1:0]          o_cfg_state
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  // Config acceptor: INIT holds ready low for the first edge after reset,
  // GAP enforces one idle cycle after every accept.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_READY = 2'd1,
    S_GAP   = 2'd2
  } cfg_state_t;

  cfg_state_t            r_state;
  cfg_state_t            w_state_nxt;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_ch_ok;

  logic [PRE_W-1:0]      r_pre_cnt;
  logic                  r_tick;
  logic [PWM_BITS-1:0]   r_pwm_cnt;

  logic [1:0]            r_mode   [CHANNELS];
  logic [15:0]           r_period [CHANNELS];
  logic [PWM_BITS-1:0]   r_duty   [CHANNELS];
  logic [15:0]           r_bcnt   [CHANNELS];
  logic [CHANNELS-1:0]   r_phase;
  logic [CHANNELS-1:0]   r_led;
  logic [CHANNELS-1:0]   w_led_nxt;

  // Prescaler: pre_cnt wraps at DIV-1; TICK is high the cycle after the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= (r_pre_cnt == PRE_LAST);
      r_pre_cnt <= (r_pre_cnt == PRE_LAST) ? '0 : r_pre_cnt + PRE_W'(1);
    end
  end

  // Config FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  // Config FSM next state and ready output.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    unique case (r_state)
      S_INIT:  w_state_nxt = S_READY;
      S_READY: begin
        w_ready = 1'b1;
        if (i_cfg.cfg_valid) w_state_nxt = S_GAP;
      end
      S_GAP:   w_state_nxt = S_READY;
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_accept        = w_ready & i_cfg.cfg_valid;
  // Out-of-range channels still complete the handshake but write nothing.
  assign w_ch_ok         = (32'(i_cfg.cfg_ch) < CHANNELS);
  assign i_cfg.cfg_ready = w_ready;
  assign o_cfg_state     = r_state;

  // Shared PWM counter, free-running every clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pwm_cnt <= '0;
    else          r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
  end

  // Channel state: a config write wins over a same-edge tick and restarts
  // the blink counter/phase; otherwise BLINK channels advance on TICK.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_mode[c]   <= MODE_OFF;
        r_period[c] <= 16'd1;
        r_duty[c]   <= '0;
        r_bcnt[c]   <= '0;
      end
      r_phase <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_accept && w_ch_ok && (32'(i_cfg.cfg_ch) == c)) begin
          r_mode[c]   <= i_cfg.cfg_mode;
          r_period[c] <= (i_cfg.cfg_period == 16'd0) ? 16'd1 : i_cfg.cfg_period;
          r_duty[c]   <= i_cfg.cfg_duty;
          r_bcnt[c]   <= '0;
          r_phase[c]  <= 1'b0;
        end else if (r_tick && (r_mode[c] == MODE_BLINK)) begin
          if (r_bcnt[c] >= r_period[c] - 16'd1) begin
            r_bcnt[c]  <= '0;
            r_phase[c] <= ~r_phase[c];
          end else begin
            r_bcnt[c]  <= r_bcnt[c] + 16'd1;
          end
        end
      end
    end
  end

  // Per-channel LED level from mode and state; all-ones duty means fully on.
  always_comb begin
    w_led_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      unique case (r_mode[c])
        MODE_OFF:   w_led_nxt[c] = 1'b0;
        MODE_ON:    w_led_nxt[c] = 1'b1;
        MODE_BLINK: w_led_nxt[c] = r_phase[c];
        MODE_PWM:   w_led_nxt[c] = (r_duty[c] == '1) | (r_pwm_cnt < r_duty[c]);
        default:    w_led_nxt[c] = 1'b0;
      endcase
    end
  end

  // Registered LED drive; async reset forces the pins low immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_led <= '0;
    else          r_led <= w_led_nxt;
  end

  assign o_led  = r_led;
  assign o_tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (DIV=10). A second instance with three
// channels exercises out-of-range channel numbers on the 2-bit channel field.
module tb_led_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       tick_a, tick_b;
  logic [3:0] led_a;
  logic [2:0] led_b;
  logic [1:0] st_a, st_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  led_pattern_gen_if #(.CH_W(2), .PWM_BITS(8)) cfg_a ();
  led_pattern_gen_if #(.CH_W(2), .PWM_BITS(8)) cfg_b ();

  led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(4), .PWM_BITS(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg(cfg_a.slave),
    .o_tick(tick_a), .o_led(led_a), .o_cfg_state(st_a)
  );

  led_pattern_gen #(.CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(3), .PWM_BITS(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg(cfg_b.slave),
    .o_tick(tick_b), .o_led(led_b), .o_cfg_state(st_b)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit use_b, input logic v, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [15:0] period, input logic [7:0] duty);
    if (use_b) begin
      cfg_b.cfg_valid = v; cfg_b.cfg_ch = ch; cfg_b.cfg_mode = mode;
      cfg_b.cfg_period = period; cfg_b.cfg_duty = duty;
    end else begin
      cfg_a.cfg_valid = v; cfg_a.cfg_ch = ch; cfg_a.cfg_mode = mode;
      cfg_a.cfg_period = period; cfg_a.cfg_duty = duty;
    end
  endtask

  // One config write; k returns the cycle number of the accepting edge.
  task automatic cfg_write(input bit use_b, input logic [1:0] ch, input logic [1:0] mode,
                           input logic [15:0] period, input logic [7:0] duty, output int k);
    int guard;
    guard = 0;
    drive(use_b, 1'b1, ch, mode, period, duty);
    while (!(use_b ? cfg_b.cfg_ready : cfg_a.cfg_ready) && guard < 10) begin
      step();
      guard++;
    end
    check("cfg_ready_seen", use_b ? cfg_b.cfg_ready : cfg_a.cfg_ready, 1);
    step();
    k = cyc;
    drive(use_b, 1'b0, ch, mode, period, duty);
    check("cfg_ready_gap", use_b ? cfg_b.cfg_ready : cfg_a.cfg_ready, 0);
  endtask

  // Directed sequence
  initial begin
    int k, k1, n1, rise, run, ticks, last_tick, highs;

    rst_n = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 8'd0);
    drive(1'b1, 1'b0, 2'd0, 2'd0, 16'd0, 8'd0);
    #1 rst_n = 1'b0;

    // 1: reset hold and release
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_led", led_a, 0);
      check("rst_tick", tick_a, 0);
      check("rst_ready", cfg_a.cfg_ready, 0);
    end
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", cfg_a.cfg_ready, 0);
    cyc = 0;
    step();
    check("ready_after_first_edge", cfg_a.cfg_ready, 1);
    check("state_ready", st_a, 1);
    check("led_after_release", led_a, 0);

    // 2: tick every 10 cycles, 1 cycle wide
    ticks = 0;
    last_tick = 0;
    for (int i = 0; i < 100; i++) begin
      check("tick_pattern", tick_a, ((cyc % 10) == 0) ? 1 : 0);
      if (tick_a) begin
        if (last_tick != 0) check("tick_spacing", cyc - last_tick, 10);
        last_tick = cyc;
        ticks++;
      end
      step();
    end
    check("tick_count_100", ticks, 10);

    // 3: CH1 BLINK period 3 -> 30 low / 30 high
    cfg_write(1'b0, 2'd1, 2'b10, 16'd3, 8'd0, k);
    check("blink_led_at_accept", led_a, 0);
    n1 = (k / 10) * 10 + 1;
    if (n1 <= k) n1 += 10;
    rise = 0;
    for (int i = 0; i < 200 && rise == 0; i++) begin
      step();
      check("blink_others_off", led_a & 4'b1101, 0);
      if (led_a[1]) rise = cyc;
    end
    check("blink_first_rise", rise, n1 + 21);
    run = 0;
    while (led_a[1] && run < 100) begin
      check("blink_others_off_hi", led_a & 4'b1101, 0);
      run++;
      step();
    end
    check("blink_high_run", run, 30);
    run = 0;
    while (!led_a[1] && run < 100) begin
      run++;
      step();
    end
    check("blink_low_run", run, 30);

    // 4: CH2 PWM duty 64, then 0, then 255
    cfg_write(1'b0, 2'd2, 2'b11, 16'd0, 8'd64, k);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      check("pwm64_bit", led_a[2], (((cyc - 1) % 256) < 64) ? 1 : 0);
      check("pwm64_others", led_a & 4'b1001, 0);
      highs += led_a[2];
    end
    check("pwm64_high_count", highs, 64);
    cfg_write(1'b0, 2'd2, 2'b11, 16'd0, 8'd0, k);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      highs += led_a[2];
    end
    check("pwm0_high_count", highs, 0);
    cfg_write(1'b0, 2'd2, 2'b11, 16'd0, 8'd255, k);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      highs += led_a[2];
    end
    check("pwm255_high_count", highs, 256);

    // 5: back-to-back CH0 ON, CH3 ON with valid held high
    drive(1'b0, 1'b1, 2'd0, 2'b01, 16'd0, 8'd0);
    run = 0;
    while (!cfg_a.cfg_ready && run < 10) begin
      step();
      run++;
    end
    step();
    k1 = cyc;
    drive(1'b0, 1'b1, 2'd3, 2'b01, 16'd0, 8'd0);
    check("b2b_ready_gap", cfg_a.cfg_ready, 0);
    check("b2b_ch0_latency", led_a[0], 0);
    step();
    check("b2b_ready_back", cfg_a.cfg_ready, 1);
    check("b2b_ch0_on", led_a[0], 1);
    step();
    check("b2b_second_accept_gap", cfg_a.cfg_ready, 0);
    check("b2b_accept_spacing", cyc - k1, 2);
    drive(1'b0, 1'b0, 2'd3, 2'b01, 16'd0, 8'd0);
    step();
    check("b2b_ch3_on", led_a & 4'b1101, 4'b1101);

    // Out-of-range channel on the 3-channel instance
    cfg_write(1'b1, 2'd3, 2'b01, 16'd0, 8'd0, k);
    for (int i = 0; i < 5; i++) begin
      step();
      check("oor_led_unchanged", led_b, 0);
    end
    check("oor_ready_returns", cfg_b.cfg_ready, 1);
    // PERIOD=0 stored as 1: toggle every tick
    cfg_write(1'b1, 2'd0, 2'b10, 16'd0, 8'd0, k);
    rise = 0;
    for (int i = 0; i < 40 && rise == 0; i++) begin
      step();
      if (led_b[0]) rise = cyc;
    end
    check("period0_rise_seen", (rise != 0) ? 1 : 0, 1);
    run = 0;
    while (led_b[0] && run < 50) begin
      run++;
      step();
    end
    check("period0_high_run", run, 10);

    // 6: async reset mid-operation
    rst_n = 1'b0;
    #1;
    check("async_led_a", led_a, 0);
    check("async_led_b", led_b, 0);
    check("async_tick", tick_a, 0);
    check("async_ready", cfg_a.cfg_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
    step();
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      highs += (led_a != 0) ? 1 : 0;
    end
    check("post_reset_all_off", highs, 0);
    cfg_write(1'b0, 2'd1, 2'b01, 16'd0, 8'd0, k);
    check("rewrite_latency", led_a, 0);
    step();
    check("rewrite_ch1_on", led_a, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
